// File: rtl/pcs_gb_pkg.sv
// Shared constants and types for the FIFO read-side 3:1 gearbox.
package pcs_gb_pkg;

  localparam int GB_WIDTH  = 192;
  localparam int GB_OWIDTH = 64;
  localparam int GB_RATIO  = 3;

  // Phase = index of the slice currently presented; encoding 3 is never entered.
  typedef enum logic [1:0] {
    PH_S0 = 2'd0,
    PH_S1 = 2'd1,
    PH_S2 = 2'd2
  } phase_t;

  localparam phase_t PH_FIRST = PH_S0;
  localparam phase_t PH_LAST  = PH_S2;

  // Advance to the next slice, wrapping after the last one.
  function automatic phase_t phase_inc(input phase_t p);
    case (p)
      PH_S0:   phase_inc = PH_S1;
      PH_S1:   phase_inc = PH_S2;
      default: phase_inc = PH_FIRST;
    endcase
  endfunction

endpackage

// File: rtl/gb_slice_mux.sv
// Selects the OWIDTH slice of the held word addressed by the current phase.
module gb_slice_mux
  import pcs_gb_pkg::*;
#(
  parameter int WIDTH  = GB_WIDTH,
  parameter int OWIDTH = GB_OWIDTH
) (
  input  logic [WIDTH-1:0]  word,
  input  phase_t            phase,
  output logic [OWIDTH-1:0] slice
);

  // Lane 0 is the least significant slice and goes out first.
  logic [GB_RATIO-1:0][OWIDTH-1:0] lanes;

  assign lanes = word;

  // Phase-indexed lane select; the unused encoding falls back to lane 0.
  always_comb begin
    slice = lanes[0];
    case (phase)
      PH_S1:   slice = lanes[1];
      PH_S2:   slice = lanes[2];
      default: ;
    endcase
  end

endmodule

// File: rtl/fifo_rd_gearbox.sv
// Breaks each WIDTH-bit FIFO word into three OWIDTH slices, lowest first,
// with zero-bubble back-to-back words and a running consumed-word count.
module fifo_rd_gearbox
  import pcs_gb_pkg::*;
#(
  parameter int WIDTH  = GB_WIDTH,
  parameter int OWIDTH = GB_OWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_enable,
  input  logic              in_flush,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_datavalid,
  output logic              out_idle,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_datavalid,
  output logic              out_sof,
  input  logic              in_idle,
  output logic [15:0]       out_wordcnt
);

  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_valid, hold_valid_nxt;
  phase_t           phase, phase_nxt;
  logic [15:0]      wordcnt, wordcnt_nxt;

  logic active;
  logic xfer;
  logic consume;

  // Reset is folded in so nothing is offered or accepted during the reset cycle.
  assign active        = !reset && in_enable && !in_flush;
  assign out_datavalid = active && hold_valid;
  assign out_sof       = out_datavalid && (phase == PH_FIRST);
  // Ready when empty, or when the last slice is leaving this very cycle.
  assign out_idle      = active && (!hold_valid || (phase == PH_LAST && in_idle));
  assign out_wordcnt   = wordcnt;

  assign xfer    = out_datavalid && in_idle;
  assign consume = out_idle && in_datavalid;

  // Next-state: flush wins, then a new word load, then slice advance.
  always_comb begin
    hold_nxt       = hold;
    hold_valid_nxt = hold_valid;
    phase_nxt      = phase;
    wordcnt_nxt    = wordcnt;
    if (in_enable) begin
      if (in_flush) begin
        hold_valid_nxt = 1'b0;
        phase_nxt      = PH_FIRST;
      end else if (consume) begin
        hold_nxt       = in_data;
        hold_valid_nxt = 1'b1;
        phase_nxt      = PH_FIRST;
        wordcnt_nxt    = wordcnt + 16'd1;
      end else if (xfer) begin
        phase_nxt = phase_inc(phase);
        if (phase == PH_LAST) hold_valid_nxt = 1'b0;
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      phase      <= PH_FIRST;
      wordcnt    <= '0;
    end else begin
      hold       <= hold_nxt;
      hold_valid <= hold_valid_nxt;
      phase      <= phase_nxt;
      wordcnt    <= wordcnt_nxt;
    end
  end

  gb_slice_mux #(
    .WIDTH  (WIDTH),
    .OWIDTH (OWIDTH)
  ) u_mux (
    .word  (hold),
    .phase (phase),
    .slice (out_data)
  );

endmodule

// File: tb/tb_fifo_rd_gearbox.sv
// Bench for fifo_rd_gearbox: directed scenarios plus random traffic, checked
// against a slice-queue model of the gearbox.
module tb_fifo_rd_gearbox;

  localparam int W  = 192;
  localparam int OW = 64;

  logic          clk = 1'b0;
  logic          reset, in_enable, in_flush, in_datavalid, in_idle;
  logic [W-1:0]  in_data;
  logic          out_idle, out_datavalid, out_sof;
  logic [OW-1:0] out_data;
  logic [15:0]   out_wordcnt;

  always #5 clk = ~clk;

  fifo_rd_gearbox #(.WIDTH(W), .OWIDTH(OW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_enable     (in_enable),
    .in_flush      (in_flush),
    .in_data       (in_data),
    .in_datavalid  (in_datavalid),
    .out_idle      (out_idle),
    .out_data      (out_data),
    .out_datavalid (out_datavalid),
    .out_sof       (out_sof),
    .in_idle       (in_idle),
    .out_wordcnt   (out_wordcnt)
  );

  // Model: every accepted word becomes three pending slices, delivered in order.
  typedef struct {
    logic [OW-1:0] d;
    int            idx;
  } slc_t;

  slc_t        mq[$];
  logic [15:0] mcnt;
  int          vectors = 0;
  int          miscompares = 0;
  bit          took;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: drive, check combinational outputs mid-cycle, advance the model.
  task automatic step(input bit rst, input bit en, input bit fl, input bit dv,
                      input logic [W-1:0] d, input bit idl, output bit tk);
    bit ev, ei, es;
    reset = rst; in_enable = en; in_flush = fl;
    in_datavalid = dv; in_data = d; in_idle = idl;
    ev = !rst && en && !fl && (mq.size() > 0);
    ei = !rst && en && !fl && (mq.size() == 0 || (mq.size() == 1 && idl));
    es = ev && (mq[0].idx == 0);
    @(negedge clk);
    chk("datavalid", {63'd0, out_datavalid}, {63'd0, ev});
    chk("idle", {63'd0, out_idle}, {63'd0, ei});
    chk("sof", {63'd0, out_sof}, {63'd0, es});
    chk("wordcnt", {48'd0, out_wordcnt}, {48'd0, mcnt});
    if (ev) chk("data", out_data, mq[0].d);
    @(posedge clk);
    tk = ei && dv;
    if (rst) begin
      mq.delete();
      mcnt = 16'd0;
    end else if (en) begin
      if (fl) mq.delete();
      else begin
        if (ev && idl) void'(mq.pop_front());
        if (tk) begin
          for (int i = 0; i < 3; i++) mq.push_back('{d: d[i*OW +: OW], idx: i});
          mcnt = mcnt + 16'd1;
        end
      end
    end
    #1;
  endtask

  // Offer words back to back until each has been accepted, then drain.
  task automatic stream(input int nwords, input bit fixed, input logic [W-1:0] w0,
                        input logic [W-1:0] w1);
    int k = 0;
    logic [W-1:0] cur;
    bit tk;
    cur = fixed ? w0 : rnd_word();
    for (int c = 0; c < 6 * nwords + 10 && (k < nwords || mq.size() > 0); c++) begin
      step(0, 1, 0, k < nwords, cur, 1, tk);
      if (tk) begin
        k++;
        cur = fixed ? w1 : rnd_word();
      end
    end
    chk("stream_done", 64'(k), 64'(nwords));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b;
    reset = 1'b1; in_enable = 1'b1; in_flush = 1'b0;
    in_datavalid = 1'b0; in_data = '0; in_idle = 1'b1;
    mcnt = 16'd0;
    @(posedge clk); @(posedge clk); #1;

    // Reset cycle: nothing offered, nothing accepted; ready the cycle after.
    step(1, 1, 0, 0, '0, 1, took);
    step(0, 1, 0, 0, '0, 1, took);
    chk("reset_data", out_data, 64'd0);

    // Single word, slices 1,2,3.
    a = mk(64'd1, 64'd2, 64'd3);
    step(0, 1, 0, 1, a, 1, took);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0, 1, took);
    chk("cnt_one", {48'd0, out_wordcnt}, 64'd1);

    // Two words back to back, no bubble.
    b = mk(64'h11, 64'h22, 64'h33);
    stream(2, 1, a, b);
    chk("cnt_three", {48'd0, out_wordcnt}, 64'd3);

    // Downstream stall at phase 1 with a word waiting upstream.
    step(0, 1, 0, 1, rnd_word(), 1, took);
    step(0, 1, 0, 0, '0, 1, took);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, rnd_word(), 0, took);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0, 1, took);

    // Flush at phase 1, then a fresh word starts at slice 0.
    step(0, 1, 0, 1, rnd_word(), 1, took);
    step(0, 1, 0, 0, '0, 1, took);
    step(0, 1, 1, 1, rnd_word(), 1, took);
    step(0, 1, 0, 0, '0, 1, took);
    stream(1, 0, '0, '0);

    // Reset at phase 2 with a word waiting.
    step(0, 1, 0, 1, rnd_word(), 1, took);
    step(0, 1, 0, 0, '0, 1, took);
    step(0, 1, 0, 0, '0, 1, took);
    step(1, 1, 0, 1, rnd_word(), 1, took);
    chk("cnt_after_reset", {48'd0, out_wordcnt}, 64'd0);
    stream(1, 0, '0, '0);

    // Counter wrap: preload near the top, then consume two words.
    mcnt = 16'hFFFE;
    force dut.wordcnt = 16'hFFFE;
    step(0, 1, 0, 0, '0, 1, took);
    release dut.wordcnt;
    stream(1, 0, '0, '0);
    chk("cnt_ffff", {48'd0, out_wordcnt}, 64'hFFFF);
    stream(1, 0, '0, '0);
    chk("cnt_wrap", {48'd0, out_wordcnt}, 64'd0);

    // Random traffic including enable gaps, flushes and resets.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
           rnd_word(), $urandom_range(0, 9) < 7, took);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_gearbox.md
FIFO_RD_GEARBOX -- requirements
Module: fifo_rd_gearbox

Interface
REQ-001 SHALL have parameter WIDTH, default 192, meaning the input word width (read side of the CDC FIFO).
REQ-002 SHALL have parameter OWIDTH, default 64, meaning the output slice width; WIDTH SHALL equal 3*OWIDTH.
REQ-003 SHALL have port clk  input  1  single clock for all logic, posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_enable  input  1  block enable; low freezes all state.
REQ-006 SHALL have port in_flush  input  1  discard any partially emitted word.
REQ-007 SHALL have port in_data  input  WIDTH  word from FIFO read port.
REQ-008 SHALL have port in_datavalid  input  1  FIFO has a word on in_data.
REQ-009 SHALL have port out_idle  output  1  ready to FIFO; a word is consumed when out_idle && in_datavalid.
REQ-010 SHALL have port out_data  output  OWIDTH  current output slice.
REQ-011 SHALL have port out_datavalid  output  1  out_data valid.
REQ-012 SHALL have port out_sof  output  1  high on slice 0 of each word.
REQ-013 SHALL have port in_idle  input  1  downstream ready; a slice transfers when out_datavalid && in_idle.
REQ-014 SHALL have port out_wordcnt  output  16  count of words consumed, wraps 0xFFFF->0.

Function
REQ-015 SHALL hold one WIDTH-bit register (hold), a hold_valid bit, and a 2-bit phase counter (values 0,1,2 only).
REQ-016 SHALL drive out_data = hold[phase*OWIDTH +: OWIDTH], slice 0 = bits [OWIDTH-1:0] emitted first.
REQ-017 SHALL drive out_datavalid = in_enable && hold_valid && !in_flush; out_sof = out_datavalid && phase==0.
REQ-018 SHALL drive out_idle = in_enable && !in_flush && (!hold_valid || (phase==2 && in_idle)), combinationally.
REQ-019 On slice transfer with phase 0 or 1: phase increments, hold unchanged.
REQ-020 On slice transfer with phase 2: phase returns to 0; if a word is consumed the same cycle, hold loads in_data and hold_valid stays 1 (zero-bubble back-to-back), else hold_valid clears.
REQ-021 When !hold_valid and a word is consumed: hold loads in_data, hold_valid sets, phase=0; slice 0 is visible the following cycle (latency 1 clk).
REQ-022 Sustained throughput SHALL be 1 word per 3 clk when in_datavalid and in_idle stay high.
REQ-023 in_idle low SHALL hold out_data, phase and hold stable; no word consumed.
REQ-024 in_flush high (with in_enable) SHALL clear hold_valid and phase next cycle, consume nothing, transfer nothing; flush has priority over all other events.
REQ-025 in_enable low SHALL freeze hold, hold_valid, phase, out_wordcnt; outputs valid/ready forced low.
REQ-026 out_wordcnt SHALL increment by 1 each cycle a word is consumed.

Reset
REQ-027 reset SHALL take priority over in_enable and in_flush.
REQ-028 On reset: hold=0, hold_valid=0, phase=0, out_wordcnt=0; hence out_datavalid=0, out_sof=0, out_data=0, out_idle low during reset cycle and high (if in_enable) the cycle after.
REQ-029 Reset asserted mid-word SHALL discard remaining slices; no slice of that word SHALL appear after reset.

Structure
REQ-030 Package pcs_gb_pkg SHALL hold WIDTH/OWIDTH defaults, ratio constant 3, and phase encoding constants.
REQ-031 A sub-module gb_slice_mux (phase -> OWIDTH slice select) SHALL be the only sub-module.

Verification
REQ-032 Reset then in_data=A (A[63:0]=1,[127:64]=2,[191:128]=3), in_datavalid=1 one cycle, in_idle=1 -> out_data 1,2,3 on next 3 cycles, out_sof on first, out_wordcnt=1.
REQ-033 Continuous words A,B, in_idle=1 -> 6 consecutive valid slices, no bubble, out_idle high only on phase-2 cycles, out_wordcnt=2.
REQ-034 in_idle low for 4 cycles at phase 1 -> out_data held at slice 1, phase 1 retained, no word consumed.
REQ-035 in_flush pulse at phase 1 -> out_datavalid low that cycle and next; following word starts at slice 0 with out_sof=1.
REQ-036 reset at phase 2 with in_datavalid=1 -> no slice 2 emitted, out_wordcnt=0, first post-reset slice is slice 0 of a new word.
REQ-037 0xFFFF words consumed then one more -> out_wordcnt=0.
